// File: rtl/router_pkg.sv
// Shared router types and defaults: ingress port ids, egress arbiter states, size constants.
package router_pkg;

    localparam int unsigned NUM_PORTS      = 5;
    localparam int unsigned PORT_W         = $clog2(NUM_PORTS);
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_TIMEOUT    = 64;

    typedef enum logic [PORT_W-1:0] {
        CENTRAL = PORT_W'(0),
        NORTH   = PORT_W'(1),
        SOUTH   = PORT_W'(2),
        EAST    = PORT_W'(3),
        WEST    = PORT_W'(4)
    } port_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/clk_rst_if.sv
// Clock plus one-cycle synchronous active-high reset bundle shared by router blocks.
interface clk_rst_if;

    logic clk;
    logic arst;

    modport sink   (input  clk, input  arst);
    modport source (output clk, output arst);

endinterface

// File: rtl/router_egress_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted req scanning ptr, ptr+1, ... modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;

    // ptr < NUM_REQ, so one conditional subtract is enough for the wrap
    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        any_c    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any_c && req[cand]) begin
                any_c          = 1'b1;
                idx_c          = cand;
                onehot_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_egress_arbiter.sv
// Per-egress-port switch allocator: round-robin, packet-locked grant with credit flow
// control toward the downstream input FIFO and a watchdog that frees stalled grants.
module router_egress_arbiter
    import router_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_PORTS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    clk_rst_if.sink                          clk_if,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic                             out_ready,
    input  logic                             credit_ret,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [$clog2(NUM_REQ)-1:0]       gnt_idx,
    output logic                             locked,
    output logic                             out_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  credits,
    output logic                             err_timeout,
    output logic                             err_credit
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WD_W   = $clog2(TIMEOUT);

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [WD_W-1:0]    wdog;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .ptr      (rr_ptr),
        .onehot_c (pick_oh),
        .idx_c    (pick_idx),
        .any_c    (pick_any)
    );

    // A flit moves only while the owner still presents it and a downstream slot is free
    assign fire      = locked & req[gnt_idx] & out_ready & (credits != '0) & ~clk_if.arst;
    assign out_valid = fire;
    assign rr_next   = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);

    always_ff @(posedge clk_if.clk) begin
        if (clk_if.arst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            locked      <= 1'b0;
            rr_ptr      <= '0;
            credits     <= CRED_MAX;
            wdog        <= '0;
            err_timeout <= 1'b0;
            err_credit  <= 1'b0;
        end else begin
            err_timeout <= 1'b0;

            // Simultaneous fire and return cancel; a surplus return is flagged, not counted
            if (fire && !credit_ret) begin
                credits <= credits - CRED_W'(1);
            end else if (credit_ret && !fire) begin
                if (credits == CRED_MAX) begin
                    err_credit <= 1'b1;
                end else begin
                    credits <= credits + CRED_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= LOCKED;
                        locked  <= 1'b1;
                        gnt     <= pick_oh;
                        gnt_idx <= pick_idx;
                        wdog    <= '0;
                    end
                end
                LOCKED: begin
                    if (fire) begin
                        wdog <= '0;
                        if (req_last[gnt_idx]) begin
                            state  <= IDLE;
                            locked <= 1'b0;
                            gnt    <= '0;
                            rr_ptr <= rr_next;
                        end
                    end else if (wdog == WD_LAST) begin
                        state       <= IDLE;
                        locked      <= 1'b0;
                        gnt         <= '0;
                        rr_ptr      <= rr_next;
                        wdog        <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                    gnt    <= '0;
                end
            endcase
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_if.clk) disable iff (clk_if.arst)
        $onehot0(gnt));
    a_lock_gnt: assert property (@(posedge clk_if.clk) disable iff (clk_if.arst)
        locked == (gnt != '0));
    a_cred_max: assert property (@(posedge clk_if.clk) disable iff (clk_if.arst)
        credits <= CRED_MAX);

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Bench for router_egress_arbiter: vector table, directed corner sequences and random
// traffic, all checked cycle by cycle against a queue-free behavioural allocator model.
module tb_router_egress_arbiter;

    localparam int NR = 5;
    localparam int FD = 16;
    localparam int TO = 64;

    clk_rst_if cif ();

    logic [NR-1:0] req;
    logic [NR-1:0] req_last;
    logic          out_ready;
    logic          credit_ret;
    logic [NR-1:0] gnt;
    logic [2:0]    gnt_idx;
    logic          locked;
    logic          out_valid;
    logic [4:0]    credits;
    logic          err_timeout;
    logic          err_credit;

    router_egress_arbiter #(
        .NUM_REQ    (NR),
        .FIFO_DEPTH (FD),
        .TIMEOUT    (TO)
    ) dut (
        .clk_if      (cif),
        .req         (req),
        .req_last    (req_last),
        .out_ready   (out_ready),
        .credit_ret  (credit_ret),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .locked      (locked),
        .out_valid   (out_valid),
        .credits     (credits),
        .err_timeout (err_timeout),
        .err_credit  (err_credit)
    );

    initial begin
        cif.clk = 1'b0;
        forever #5 cif.clk = ~cif.clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner number, round-robin start, credit and stall counts as integers
    bit m_ok = 1'b0;
    bit m_locked;
    int m_owner;
    int m_rr;
    int m_cred;
    int m_wd;
    bit m_errt;
    bit m_errc;

    logic [NR-1:0] last_gnt;
    logic          last_locked;
    logic          last_valid;
    logic [4:0]    last_cred;
    logic          last_errt;
    logic          last_errc;

    typedef struct {
        bit            rst;
        logic [NR-1:0] r;
        logic [NR-1:0] l;
        bit            rdy;
        bit            cr;
        bit            chk;
        logic [NR-1:0] e_gnt;
        bit            e_lock;
        bit            e_val;
        logic [4:0]    e_cred;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_release();
        m_locked = 1'b0;
        m_rr     = (m_owner + 1) % NR;
        m_wd     = 0;
    endtask

    // One clock: drive inputs after the falling edge, compare, then advance the model
    task automatic step(input bit rst, input logic [NR-1:0] r, input logic [NR-1:0] l,
                        input bit rdy, input bit cr);
        bit f;
        int pick;
        @(negedge cif.clk);
        cif.arst   = rst;
        req        = r;
        req_last   = l;
        out_ready  = rdy;
        credit_ret = cr;
        #1;
        last_gnt    = gnt;
        last_locked = locked;
        last_valid  = out_valid;
        last_cred   = credits;
        last_errt   = err_timeout;
        last_errc   = err_credit;
        f = m_ok && !rst && m_locked && (((r >> m_owner) & 5'd1) != 5'd0) && rdy && (m_cred > 0);
        if (m_ok) begin
            chk("gnt", 32'(gnt), m_locked ? (32'd1 << m_owner) : 32'd0);
            chk("locked", 32'(locked), 32'(m_locked));
            if (m_locked) chk("gnt_idx", 32'(gnt_idx), 32'(m_owner));
            chk("out_valid", 32'(out_valid), 32'(f));
            chk("credits", 32'(credits), 32'(m_cred));
            chk("err_timeout", 32'(err_timeout), 32'(m_errt));
            chk("err_credit", 32'(err_credit), 32'(m_errc));
        end
        if (rst) begin
            m_ok = 1'b1; m_locked = 1'b0; m_owner = 0; m_rr = 0;
            m_cred = FD; m_wd = 0; m_errt = 1'b0; m_errc = 1'b0;
        end else if (m_ok) begin
            m_errt = 1'b0;
            if (f && !cr) m_cred--;
            else if (cr && !f) begin
                if (m_cred == FD) m_errc = 1'b1;
                else m_cred++;
            end
            if (!m_locked) begin
                pick = -1;
                for (int k = 0; k < NR; k++)
                    if (pick < 0 && ((r >> ((m_rr + k) % NR)) & 5'd1) != 5'd0) pick = (m_rr + k) % NR;
                if (pick >= 0) begin
                    m_locked = 1'b1; m_owner = pick; m_wd = 0;
                end
            end else if (f) begin
                m_wd = 0;
                if (((l >> m_owner) & 5'd1) != 5'd0) model_release();
            end else if (m_wd == TO - 1) begin
                model_release();
                m_errt = 1'b1;
            end else begin
                m_wd++;
            end
        end
    endtask

    function automatic vec_t mk(input bit rst, input logic [NR-1:0] r, input logic [NR-1:0] l,
                                input bit rdy, input bit cr, input bit c, input logic [NR-1:0] eg,
                                input bit el, input bit ev, input logic [4:0] ec);
        vec_t v;
        v.rst = rst; v.r = r; v.l = l; v.rdy = rdy; v.cr = cr; v.chk = c;
        v.e_gnt = eg; v.e_lock = el; v.e_val = ev; v.e_cred = ec;
        return v;
    endfunction

    initial begin
        int p1, first3, sent, errt_cnt, errt_cyc;
        logic [NR-1:0] r, l, g66;
        req = '0; req_last = '0; out_ready = 1'b0; credit_ret = 1'b0;
        cif.arst = 1'b1;

        // Single-flit packet, then all-ports round robin with matched credit returns
        vecs[0]  = mk(1, 5'b00000, 5'b00000, 0, 0, 0, 5'b00000, 0, 0, 5'd16);
        vecs[1]  = mk(0, 5'b00100, 5'b00100, 1, 0, 1, 5'b00000, 0, 0, 5'd16);
        vecs[2]  = mk(0, 5'b00100, 5'b00100, 1, 0, 1, 5'b00100, 1, 1, 5'd16);
        vecs[3]  = mk(0, 5'b00000, 5'b00000, 1, 0, 1, 5'b00000, 0, 0, 5'd15);
        vecs[4]  = mk(1, 5'b00000, 5'b00000, 0, 0, 0, 5'b00000, 0, 0, 5'd16);
        vecs[5]  = mk(0, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000, 0, 0, 5'd16);
        vecs[6]  = mk(0, 5'b11111, 5'b11111, 1, 1, 1, 5'b00001, 1, 1, 5'd16);
        vecs[7]  = mk(0, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000, 0, 0, 5'd16);
        vecs[8]  = mk(0, 5'b11111, 5'b11111, 1, 1, 1, 5'b00010, 1, 1, 5'd16);
        vecs[9]  = mk(0, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000, 0, 0, 5'd16);
        vecs[10] = mk(0, 5'b11111, 5'b11111, 1, 1, 1, 5'b00100, 1, 1, 5'd16);
        vecs[11] = mk(0, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000, 0, 0, 5'd16);
        vecs[12] = mk(0, 5'b11111, 5'b11111, 1, 1, 1, 5'b01000, 1, 1, 5'd16);
        vecs[13] = mk(0, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000, 0, 0, 5'd16);
        vecs[14] = mk(0, 5'b11111, 5'b11111, 1, 1, 1, 5'b10000, 1, 1, 5'd16);
        vecs[15] = mk(0, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000, 0, 0, 5'd16);
        vecs[16] = mk(0, 5'b11111, 5'b11111, 1, 1, 1, 5'b00001, 1, 1, 5'd16);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].r, vecs[i].l, vecs[i].rdy, vecs[i].cr);
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_gnt", i), 32'(last_gnt), 32'(vecs[i].e_gnt));
                chk($sformatf("vec%0d_locked", i), 32'(last_locked), 32'(vecs[i].e_lock));
                chk($sformatf("vec%0d_valid", i), 32'(last_valid), 32'(vecs[i].e_val));
                chk($sformatf("vec%0d_credits", i), 32'(last_cred), 32'(vecs[i].e_cred));
            end
        end

        // 4-flit packet on port 1 holds the grant while port 3 waits
        step(1, '0, '0, 0, 0);
        p1 = 0; first3 = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            r = ((p1 < 4) ? 5'b00010 : 5'b00000) | 5'b01000;
            l = ((p1 == 3) ? 5'b00010 : 5'b00000) | 5'b01000;
            step(0, r, l, 1, 0);
            if (last_valid && last_gnt == 5'b00010) p1++;
            if (last_gnt == 5'b01000 && first3 < 0) begin
                first3 = cyc;
                chk("t3_p1_flits_before_p3", 32'(p1), 32'd4);
            end
        end
        chk("t3_p3_granted_cycle", 32'(first3), 32'd6);

        // Credit exhaustion, then one returned credit releases exactly one flit
        step(1, '0, '0, 0, 0);
        sent = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            r = (sent < 20) ? 5'b00001 : 5'b00000;
            step(0, r, r, 1, 0);
            if (last_valid) sent++;
        end
        chk("t4_fires", 32'(sent), 32'd16);
        chk("t4_credits_zero", 32'(last_cred), 32'd0);
        step(0, 5'b00001, 5'b00001, 1, 1);
        if (last_valid) sent++;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step(0, 5'b00001, 5'b00001, 1, 0);
            if (last_valid) sent++;
        end
        chk("t4_fires_after_return", 32'(sent), 32'd17);

        // Watchdog: port 2 locked with ready low releases after TIMEOUT stalled cycles
        step(1, '0, '0, 0, 0);
        errt_cnt = 0; errt_cyc = -1; g66 = '0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            step(0, 5'b01100, 5'b00000, 0, 0);
            if (last_errt) begin
                errt_cnt++;
                errt_cyc = cyc;
            end
            if (cyc == 1) chk("t5_locked_port2", 32'(last_gnt), 32'b00100);
            if (cyc == 66) g66 = last_gnt;
        end
        chk("t5_errt_pulses", 32'(errt_cnt), 32'd1);
        chk("t5_errt_cycle", 32'(errt_cyc), 32'd65);
        chk("t5_next_grant", 32'(g66), 32'b01000);

        // Surplus credit return is sticky; reset mid-packet clears everything without a fire
        step(1, '0, '0, 0, 0);
        step(0, '0, '0, 1, 1);
        step(0, '0, '0, 1, 0);
        chk("t6_err_credit_set", 32'(last_errc), 32'd1);
        chk("t6_credits_hold", 32'(last_cred), 32'd16);
        step(0, 5'b00001, 5'b00000, 1, 0);
        step(0, 5'b00001, 5'b00000, 1, 0);
        step(0, 5'b00001, 5'b00000, 1, 0);
        step(1, 5'b00001, 5'b00000, 1, 0);
        chk("t6_no_fire_in_reset", 32'(last_valid), 32'd0);
        step(0, '0, '0, 1, 0);
        chk("t6_gnt_cleared", 32'(last_gnt), 32'd0);
        chk("t6_credits_restored", 32'(last_cred), 32'd16);
        chk("t6_err_credit_cleared", 32'(last_errc), 32'd0);

        // Random traffic against the model
        step(1, '0, '0, 0, 0);
        for (int cyc = 0; cyc < 800; cyc++) begin
            r = 5'($urandom_range(0, 31));
            l = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
            step(($urandom_range(0, 199) == 0), r, l, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
